frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer.sv | 189 ++++++++++++++++++
 tb/tb_frame_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
//   Captures a pixel stream into one of two ping-pong frame buffers. Buffers
//   are used in strict alternation (0,1,0,1...). Before each frame the writer
//   waits for the display side to report the target buffer empty, then waits
//   for a start-of-frame beat and writes FRAME_PX words at addresses
//   0..FRAME_PX-1. A completed frame pulses BufferxFull and bumps FrameWInd.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   pix_valid/pix_ready source handshake; beat accepted when both are high
//   pix_sof             beat is the first pixel of a frame
//   pix_r/pix_g/pix_b   8-bit colour components
//   Buf0Empty/Buf1Empty buffer drained by the display side, free to write
//   WData/WAddr         write word {8'h00,R,G,B} and pixel index
//   WE0/WE1             one-cycle write strobe to buffer 0 / 1
//   Buffer0Full/1Full   one-cycle pulse when a buffer holds a full frame
//   FrameWInd           count of completed frames (wraps)
//   sof_err             one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        pix_sof,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        Buf0Empty,
  input  logic        Buf1Empty,
  output logic [31:0] WData,
  output logic [19:0] WAddr,
  output logic        WE0,
  output logic        WE1,
  output logic        Buffer0Full,
  output logic        Buffer1Full,
  output logic [15:0] FrameWInd,
  output logic        sof_err
);

  localparam int FRAME_PX = H_ACTIVE * V_ACTIVE;

  if (H_ACTIVE < 1 || H_ACTIVE > 1023 || V_ACTIVE < 1 || V_ACTIVE > 1023) begin : g_bad_dim
    $error("frame_writer: H_ACTIVE/V_ACTIVE must be in 1..1023");
  end
  if (FRAME_PX > 1048576) begin : g_bad_size
    $error("frame_writer: H_ACTIVE*V_ACTIVE exceeds 2^20 pixels");
  end

  localparam logic [19:0] LAST_IDX = 20'(FRAME_PX - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL      = 3'd1,
    WAIT_SOF = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        next_buf_r;
  logic [19:0] addr_r;       // index the next in-order beat will be written to
  logic        accept_s;
  logic        sel_empty_s;
  logic        wr_en_s;
  logic [19:0] wr_idx_s;
  logic        err_s;

  // Ready is a decode of the state register only, so it is glitch-free and
  // drops to 0 together with the asynchronous reset.
  assign pix_ready = (state_r == WAIT_SOF) || (state_r == WRITE);
  assign accept_s  = pix_valid && pix_ready;

  // Next-state logic and decode of the write that an accepted beat causes.
  always_comb begin
    state_s     = state_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = addr_r;
    err_s       = 1'b0;
    sel_empty_s = next_buf_r ? Buf1Empty : Buf0Empty;
    case (state_r)
      IDLE: begin
        state_s = SEL;
      end
      SEL: begin
        // Only the buffer whose turn it is may be used; the other is ignored.
        if (sel_empty_s) begin
          state_s = WAIT_SOF;
        end else begin
          state_s = SEL;
        end
      end
      WAIT_SOF: begin
        if (accept_s) begin
          if (pix_sof) begin
            wr_en_s  = 1'b1;
            wr_idx_s = 20'd0;
            state_s  = (wr_idx_s == LAST_IDX) ? DONE : WRITE;
          end else begin
            // Mid-frame beat while hunting for SOF: drop it and flag.
            err_s   = 1'b1;
            state_s = WAIT_SOF;
          end
        end else begin
          state_s = WAIT_SOF;
        end
      end
      WRITE: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          if (pix_sof && (addr_r != 20'd0)) begin
            // Early SOF: abandon the partial frame, restart at pixel 0.
            err_s    = 1'b1;
            wr_idx_s = 20'd0;
          end else begin
            wr_idx_s = addr_r;
          end
          state_s = (wr_idx_s == LAST_IDX) ? DONE : WRITE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        state_s = SEL;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered write port, frame completion flags and buffer selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_buf_r  <= 1'b0;
      addr_r      <= 20'd0;
      WData       <= 32'd0;
      WAddr       <= 20'd0;
      WE0         <= 1'b0;
      WE1         <= 1'b0;
      Buffer0Full <= 1'b0;
      Buffer1Full <= 1'b0;
      FrameWInd   <= 16'd0;
      sof_err     <= 1'b0;
    end else begin
      WE0         <= wr_en_s && !next_buf_r;
      WE1         <= wr_en_s && next_buf_r;
      sof_err     <= err_s;
      // Full pulse and frame count become visible during the DONE cycle.
      Buffer0Full <= (state_s == DONE) && !next_buf_r;
      Buffer1Full <= (state_s == DONE) && next_buf_r;
      if (wr_en_s) begin
        WData  <= {8'h00, pix_r, pix_g, pix_b};
        WAddr  <= wr_idx_s;
        addr_r <= (wr_idx_s == LAST_IDX) ? 20'd0 : (wr_idx_s + 20'd1);
      end else begin
        WData  <= WData;
        WAddr  <= WAddr;
        addr_r <= addr_r;
      end
      if (state_s == DONE) begin
        FrameWInd <= FrameWInd + 16'd1;
      end else begin
        FrameWInd <= FrameWInd;
      end
      if (state_r == DONE) begin
        next_buf_r <= ~next_buf_r;
      end else begin
        next_buf_r <= next_buf_r;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_writer
//   Directed bench for frame_writer with a 4x2 frame (8 pixels). A monitor
//   records every write strobe and counts full/error pulses on the falling
//   edge; each scenario task drives beats and compares what was recorded with
//   hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid, pix_ready, pix_sof;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        Buf0Empty, Buf1Empty;
  logic [31:0] WData;
  logic [19:0] WAddr;
  logic        WE0, WE1, Buffer0Full, Buffer1Full, sof_err;
  logic [15:0] FrameWInd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        b;
    logic [19:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  int  f0_cnt, f1_cnt, err_cnt, both_cnt;

  frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
    .WData(WData), .WAddr(WAddr), .WE0(WE0), .WE1(WE1),
    .Buffer0Full(Buffer0Full), .Buffer1Full(Buffer1Full),
    .FrameWInd(FrameWInd), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  // Expected buffer word for a beat driven with value v.
  function automatic logic [31:0] exp_word(input logic [7:0] v);
    return {8'h00, v, v ^ 8'h55, ~v};
  endfunction

  // Record DUT activity mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (WE0 === 1'b1 || WE1 === 1'b1) wq.push_back('{WE1, WAddr, WData});
      if (WE0 === 1'b1 && WE1 === 1'b1) both_cnt++;
      if (Buffer0Full === 1'b1) f0_cnt++;
      if (Buffer1Full === 1'b1) f1_cnt++;
      if (sof_err === 1'b1) err_cnt++;
    end
  end

  task automatic clear_mon();
    wq.delete();
    f0_cnt = 0; f1_cnt = 0; err_cnt = 0;
  endtask

  // Offer one beat and hold it until the writer accepts it (bounded).
  task automatic put_beat(input logic [7:0] v, input logic sof);
    int waited = 0;
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = sof;
    pix_r = v; pix_g = v ^ 8'h55; pix_b = ~v;
    while (pix_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (waited >= 100) begin
      n_fail++;
      $display("FAIL beat_accept: beat %h not accepted within %0d cycles, required acceptance", v, waited);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
    Buf0Empty = 1'b1; Buf1Empty = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({pix_ready, WE0, WE1, Buffer0Full, Buffer1Full, sof_err} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000", {pix_ready, WE0, WE1, Buffer0Full, Buffer1Full, sof_err});
    end
    n_chk++;
    if (WData !== 32'd0 || WAddr !== 20'd0 || FrameWInd !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: WData=%h WAddr=%h FrameWInd=%0d, required all 0", WData, WAddr, FrameWInd);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_frame();
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      put_beat(8'(8'h10 + i), (i == 0));
      if (i == 6) Buf1Empty = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (wq.size() != 8) begin
      n_fail++;
      $display("FAIL basic_count: %0d writes, required 8", wq.size());
    end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      n_chk++;
      if (wq[i].b !== 1'b0 || wq[i].a !== 20'(i) || wq[i].d !== exp_word(8'(8'h10 + i))) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: buf=%0d addr=%0d data=%h, required buf=0 addr=%0d data=%h",
                 i, wq[i].b, wq[i].a, wq[i].d, i, exp_word(8'(8'h10 + i)));
      end
    end
    n_chk++;
    if (f0_cnt != 1 || f1_cnt != 0 || FrameWInd !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_done: full0=%0d full1=%0d FrameWInd=%0d, required 1 0 1", f0_cnt, f1_cnt, FrameWInd);
    end
  endtask

  task automatic test_buffer_wait();
    clear_mon();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_ready[%0d]: pix_ready=%b, required 0", c, pix_ready);
      end
    end
    n_chk++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL wait_nowrite: %0d writes, required 0", wq.size());
    end
    Buf1Empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put_beat(8'(8'h20 + i), (i == 0));
      if (i == 2) Buf1Empty = 1'b0;  // drop mid-frame: must not stall
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (wq.size() != 8) begin
      n_fail++;
      $display("FAIL wait_count: %0d writes, required 8", wq.size());
    end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      n_chk++;
      if (wq[i].b !== 1'b1 || wq[i].a !== 20'(i) || wq[i].d !== exp_word(8'(8'h20 + i))) begin
        n_fail++;
        $display("FAIL wait_write[%0d]: buf=%0d addr=%0d data=%h, required buf=1 addr=%0d data=%h",
                 i, wq[i].b, wq[i].a, wq[i].d, i, exp_word(8'(8'h20 + i)));
      end
    end
    n_chk++;
    if (f0_cnt != 0 || f1_cnt != 1 || FrameWInd !== 16'd2) begin
      n_fail++;
      $display("FAIL wait_done: full0=%0d full1=%0d FrameWInd=%0d, required 0 1 2", f0_cnt, f1_cnt, FrameWInd);
    end
  endtask

  task automatic test_gapped_valid();
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      put_beat(8'(8'h30 + i), (i == 0));
      @(negedge clk);  // idle cycle with pix_valid low
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (wq.size() != 8) begin
      n_fail++;
      $display("FAIL gap_count: %0d writes, required 8", wq.size());
    end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      n_chk++;
      if (wq[i].b !== 1'b0 || wq[i].a !== 20'(i) || wq[i].d !== exp_word(8'(8'h30 + i))) begin
        n_fail++;
        $display("FAIL gap_write[%0d]: buf=%0d addr=%0d data=%h, required buf=0 addr=%0d data=%h",
                 i, wq[i].b, wq[i].a, wq[i].d, i, exp_word(8'(8'h30 + i)));
      end
    end
    n_chk++;
    if (f0_cnt != 1 || FrameWInd !== 16'd3) begin
      n_fail++;
      $display("FAIL gap_done: full0=%0d FrameWInd=%0d, required 1 3", f0_cnt, FrameWInd);
    end
  endtask

  task automatic test_sof_errors();
    logic [19:0] ea;
    clear_mon();
    Buf1Empty = 1'b1;
    put_beat(8'hE0, 1'b0);  // no SOF while waiting: discarded
    for (int k = 0; k < 11; k++) begin
      put_beat(8'(8'hA0 + k), (k == 0) || (k == 3));
    end
    Buf1Empty = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (wq.size() != 11) begin
      n_fail++;
      $display("FAIL sof_count: %0d writes, required 11", wq.size());
    end
    for (int k = 0; k < wq.size() && k < 11; k++) begin
      ea = (k < 3) ? 20'(k) : 20'(k - 3);
      n_chk++;
      if (wq[k].b !== 1'b1 || wq[k].a !== ea || wq[k].d !== exp_word(8'(8'hA0 + k))) begin
        n_fail++;
        $display("FAIL sof_write[%0d]: buf=%0d addr=%0d data=%h, required buf=1 addr=%0d data=%h",
                 k, wq[k].b, wq[k].a, wq[k].d, ea, exp_word(8'(8'hA0 + k)));
      end
    end
    n_chk++;
    if (err_cnt != 2 || f1_cnt != 1 || FrameWInd !== 16'd4) begin
      n_fail++;
      $display("FAIL sof_done: sof_err=%0d full1=%0d FrameWInd=%0d, required 2 1 4", err_cnt, f1_cnt, FrameWInd);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    for (int i = 0; i < 5; i++) put_beat(8'(8'h50 + i), (i == 0));
    n_chk++;
    if (WE0 !== 1'b1 || WAddr !== 20'd4) begin
      n_fail++;
      $display("FAIL mid_prewrite: WE0=%b WAddr=%0d, required 1 4", WE0, WAddr);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if ({pix_ready, WE0, WE1, Buffer0Full, Buffer1Full, sof_err} !== 6'b000000 ||
        WData !== 32'd0 || WAddr !== 20'd0 || FrameWInd !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: flags=%b WData=%h WAddr=%h FrameWInd=%0d, required all 0",
               {pix_ready, WE0, WE1, Buffer0Full, Buffer1Full, sof_err}, WData, WAddr, FrameWInd);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    Buf0Empty = 1'b1; Buf1Empty = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (f0_cnt != 0 || f1_cnt != 0 || FrameWInd !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_nofull: full0=%0d full1=%0d FrameWInd=%0d, required 0 0 0", f0_cnt, f1_cnt, FrameWInd);
    end
    clear_mon();
    for (int i = 0; i < 8; i++) put_beat(8'(8'h60 + i), (i == 0));
    repeat (4) @(negedge clk);
    n_chk++;
    if (wq.size() != 8) begin
      n_fail++;
      $display("FAIL post_count: %0d writes, required 8", wq.size());
    end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      n_chk++;
      if (wq[i].b !== 1'b0 || wq[i].a !== 20'(i) || wq[i].d !== exp_word(8'(8'h60 + i))) begin
        n_fail++;
        $display("FAIL post_write[%0d]: buf=%0d addr=%0d data=%h, required buf=0 addr=%0d data=%h",
                 i, wq[i].b, wq[i].a, wq[i].d, i, exp_word(8'(8'h60 + i)));
      end
    end
    n_chk++;
    if (f0_cnt != 1 || f1_cnt != 0 || FrameWInd !== 16'd1) begin
      n_fail++;
      $display("FAIL post_done: full0=%0d full1=%0d FrameWInd=%0d, required 1 0 1", f0_cnt, f1_cnt, FrameWInd);
    end
  endtask

  initial begin
    both_cnt = 0;
    test_reset();
    test_basic_frame();
    test_buffer_wait();
    test_gapped_valid();
    test_sof_errors();
    test_reset_mid_frame();
    n_chk++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL we_exclusive: %0d cycles with WE0 and WE1 both high, required 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
